// File: rtl/sr_button_pkg.sv
// Shared types and constants for the set/reset pushbutton controller.
package sr_button_pkg;

  typedef enum logic [1:0] {
    StLow     = 2'd0,
    StChkHigh = 2'd1,
    StHigh    = 2'd2,
    StChkLow  = 2'd3
  } ch_state_e;

  // 10 ms at 12 MHz
  localparam int unsigned DebounceCyclesDefault = 120000;

endpackage

// File: rtl/debounce_ch.sv
// One pushbutton channel: synchronizer, 4-state debounce FSM with saturating counter,
// debounced level and a single-cycle press event on the accepted low-to-high change.
module debounce_ch
  import sr_button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_in;
  ch_state_e              r_state, w_state_d;
  logic [CntW-1:0]        r_cnt, w_cnt_d;
  logic                   w_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
    end
  end

  assign w_in = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StLow;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // The counter never increments past CntLast: reaching it always leaves the check state.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_press   = 1'b0;
    unique case (r_state)
      StLow: begin
        if (w_in) begin
          w_state_d = StChkHigh;
          w_cnt_d   = '0;
        end
      end
      StChkHigh: begin
        if (!w_in) begin
          w_state_d = StLow;
        end else if (r_cnt == CntLast) begin
          w_state_d = StHigh;
          w_press   = 1'b1;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StHigh: begin
        if (!w_in) begin
          w_state_d = StChkLow;
          w_cnt_d   = '0;
        end
      end
      StChkLow: begin
        if (w_in) begin
          w_state_d = StHigh;
        end else if (r_cnt == CntLast) begin
          w_state_d = StLow;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      default: w_state_d = StLow;
    endcase
  end

  assign o_level = (r_state == StHigh) || (r_state == StChkLow);
  assign o_press = w_press;

endmodule

// File: rtl/sr_button_ctrl.sv
// Debounces set/reset pushbuttons and emits registered one-cycle s/r pulses for an SR
// flip-flop; simultaneous presses are suppressed and flagged on conflict.
module sr_button_ctrl
  import sr_button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_btn,
  input  logic reset_btn,
  output logic s,
  output logic r,
  output logic conflict,
  output logic set_level,
  output logic reset_level
);

  logic w_set_press, w_reset_press;
  logic r_s, r_r, r_conflict;

  debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_set_ch (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (set_btn),
    .o_level(set_level),
    .o_press(w_set_press)
  );

  debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_reset_ch (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (reset_btn),
    .o_level(reset_level),
    .o_press(w_reset_press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_s        <= w_set_press & ~w_reset_press;
      r_r        <= w_reset_press & ~w_set_press;
      r_conflict <= w_set_press & w_reset_press;
    end
  end

  assign s        = r_s;
  assign r        = r_r;
  assign conflict = r_conflict;

endmodule

// File: tb/tb_sr_button_ctrl.sv
// Randomized and directed bench for sr_button_ctrl against a run-length debounce model.
module tb_sr_button_ctrl;

  localparam int unsigned Debounce = 4;
  localparam int unsigned Sync     = 2;
  localparam int          Latency  = int'(Debounce + Sync + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic set_btn = 1'b0;
  logic reset_btn = 1'b0;
  logic s, r, conflict, set_level, reset_level;

  sr_button_ctrl #(
    .DEBOUNCE_CYCLES(Debounce),
    .SYNC_STAGES    (Sync)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_btn    (set_btn),
    .reset_btn  (reset_btn),
    .s          (s),
    .r          (r),
    .conflict   (conflict),
    .set_level  (set_level),
    .reset_level(reset_level)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  // Model: raw inputs delayed by the synchronizer depth, then a level flips once the
  // delayed input has disagreed with it for Debounce+1 consecutive samples.
  bit q_set[$];
  bit q_rst[$];
  bit lvl_set, lvl_rst;
  int run_set, run_rst;
  bit e_s, e_r, e_c;

  int cnt_s, cnt_r, cnt_c, cnt_rl, last_s_cyc, last_r_cyc, start;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic void model_reset();
    q_set.delete();
    q_rst.delete();
    for (int i = 0; i < int'(Sync); i++) begin
      q_set.push_back(1'b0);
      q_rst.push_back(1'b0);
    end
    lvl_set = 1'b0;
    lvl_rst = 1'b0;
    run_set = 0;
    run_rst = 0;
    e_s = 1'b0;
    e_r = 1'b0;
    e_c = 1'b0;
  endfunction

  function automatic void chan(input bit x, inout bit lvl, inout int run, output bit press);
    press = 1'b0;
    if (x != lvl) begin
      run++;
      if (run == int'(Debounce) + 1) begin
        lvl   = x;
        run   = 0;
        press = x;
      end
    end else begin
      run = 0;
    end
  endfunction

  function automatic void clear_counts();
    cnt_s = 0;
    cnt_r = 0;
    cnt_c = 0;
    cnt_rl = 0;
    last_s_cyc = -1;
    last_r_cyc = -1;
  endfunction

  task automatic step();
    bit xs, xr, ps, pr;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      model_reset();
    end else begin
      q_set.push_back(set_btn);
      q_rst.push_back(reset_btn);
      xs = q_set.pop_front();
      xr = q_rst.pop_front();
      chan(xs, lvl_set, run_set, ps);
      chan(xr, lvl_rst, run_rst, pr);
      e_s = ps & ~pr;
      e_r = pr & ~ps;
      e_c = ps & pr;
    end
    #1;
    chk("outs", 32'({s, r, conflict, set_level, reset_level}),
        32'({e_s, e_r, e_c, lvl_set, lvl_rst}));
    chk("s_r_excl", 32'(s & r), 32'd0);
    if (s) begin cnt_s++; last_s_cyc = cyc; end
    if (r) begin cnt_r++; last_r_cyc = cyc; end
    if (conflict) cnt_c++;
    if (reset_level) cnt_rl++;
  endtask

  task automatic run_n(input int n);
    repeat (n) step();
  endtask

  // Called #1 after an edge: asserts reset asynchronously, holds it over n edges.
  task automatic pulse_reset(input int n);
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs", 32'({s, r, conflict, set_level, reset_level}), 32'd0);
    model_reset();
    run_n(n);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    clear_counts();
    #2;
    chk("reset_outs", 32'({s, r, conflict, set_level, reset_level}), 32'd0);
    run_n(3);
    rst_n = 1'b1;
    run_n(5);

    // Single held set press, then release
    clear_counts();
    start = cyc;
    set_btn = 1'b1;
    run_n(20);
    chk("s_latency", 32'(last_s_cyc - start), 32'(Latency));
    chk("s_count", 32'(cnt_s), 32'd1);
    chk("set_level_held", 32'(set_level), 32'd1);
    set_btn = 1'b0;
    run_n(Latency - 1);
    chk("set_level_pre_rel", 32'(set_level), 32'd1);
    run_n(1);
    chk("set_level_rel", 32'(set_level), 32'd0);
    run_n(5);
    chk("s_count_after_rel", 32'(cnt_s), 32'd1);
    chk("r_c_none", 32'(cnt_r + cnt_c), 32'd0);

    // Glitchy reset button never accepted
    clear_counts();
    for (int i = 0; i < 15; i++) begin
      reset_btn = ~reset_btn;
      run_n(2);
    end
    reset_btn = 1'b0;
    run_n(15);
    chk("glitch_r_count", 32'(cnt_r), 32'd0);
    chk("glitch_rlevel", 32'(cnt_rl), 32'd0);

    // Simultaneous press
    clear_counts();
    set_btn = 1'b1;
    reset_btn = 1'b1;
    run_n(20);
    chk("conflict_count", 32'(cnt_c), 32'd1);
    chk("conflict_s_r", 32'(cnt_s + cnt_r), 32'd0);
    set_btn = 1'b0;
    reset_btn = 1'b0;
    run_n(15);

    // Presses one cycle apart both pass through
    clear_counts();
    set_btn = 1'b1;
    run_n(1);
    reset_btn = 1'b1;
    run_n(20);
    chk("adj_s_count", 32'(cnt_s), 32'd1);
    chk("adj_r_count", 32'(cnt_r), 32'd1);
    chk("adj_r_after_s", 32'(last_r_cyc - last_s_cyc), 32'd1);
    chk("adj_conflict", 32'(cnt_c), 32'd0);
    set_btn = 1'b0;
    reset_btn = 1'b0;
    run_n(15);

    // Reset mid-debounce while set is held
    clear_counts();
    set_btn = 1'b1;
    run_n(3);
    pulse_reset(2);
    chk("mid_rst_no_early", 32'(cnt_s), 32'd0);
    start = cyc;
    run_n(20);
    chk("mid_rst_s_count", 32'(cnt_s), 32'd1);
    chk("mid_rst_latency", 32'(last_s_cyc - start), 32'(Latency));
    set_btn = 1'b0;
    run_n(15);

    // Long hold yields one pulse; re-press yields another
    clear_counts();
    set_btn = 1'b1;
    run_n(1000);
    chk("long_hold_count", 32'(cnt_s), 32'd1);
    set_btn = 1'b0;
    run_n(10);
    set_btn = 1'b1;
    run_n(20);
    chk("repress_count", 32'(cnt_s), 32'd2);
    set_btn = 1'b0;
    run_n(15);

    // Random run lengths, with occasional resets
    for (int i = 0; i < 200; i++) begin
      set_btn = 1'($urandom_range(0, 1));
      reset_btn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 24) == 0) pulse_reset(int'($urandom_range(1, 3)));
      run_n(int'($urandom_range(1, 12)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
